// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter.
//   state_e : arbiter FSM state (idle / burst granted)
//   NREQ    : number of requesters
//   SELW    : width of the mux select / requester index
//   next_rr : round-robin winner, scanning ptr+1, ptr+2, ptr+3, ptr
package rr_mux4_arbiter_pkg;

  localparam int unsigned NREQ = 4;
  localparam int unsigned SELW = 2;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  // The offset loop runs downwards so that the smallest offset from ptr+1 is
  // assigned last and wins. Offset 4 wraps to ptr itself, which is the lowest
  // priority. The result is ptr when req is zero; callers qualify it with |req.
  function automatic logic [SELW-1:0] next_rr(input logic [NREQ-1:0] req,
                                               input logic [SELW-1:0] ptr);
    logic [SELW-1:0] idx;
    next_rr = ptr;
    for (int i = NREQ; i >= 1; i--) begin
      idx = ptr + SELW'(i);
      if (req[idx]) next_rr = idx;
    end
  endfunction

endpackage

// File: rtl/rr_mux4_arbiter_pick.sv
// Combinational round-robin priority rotator.
//   req_i    : request vector, one bit per requester
//   ptr_i    : index of the most recently served requester (lowest priority)
//   winner_o : index of the selected requester (valid only when any_o is high)
//   any_o    : at least one request is present
module rr_pick4
  import rr_mux4_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [SELW-1:0] winner_o,
  output logic            any_o
);

  always_comb begin
    winner_o = next_rr(req_i, ptr_i);
    any_o    = |req_i;
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one 4:1 valid/ready datapath among four requesters.
// A winner is chosen in idle, registered into sel/gnt, and its data is streamed
// until the burst ends (last), the hold limit is hit, or the requester aborts.
//   clk, rst   : clock, asynchronous active-high reset
//   req, last  : per-requester valid and end-of-burst flag
//   din        : packed requester data, requester k at [k*DW +: DW]
//   out_ready  : downstream ready
//   out_valid, out_data, out_last : streamed beat from the granted requester
//   gnt, sel   : registered one-hot grant and mux select
//   busy       : a grant is active
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      last,
  input  logic [NREQ*DW-1:0]   din,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic                 out_last,
  output logic [NREQ-1:0]      gnt,
  output logic [SELW-1:0]      sel,
  output logic                 busy
);

  localparam logic [3:0] MaxHoldCnt = 4'(MAX_HOLD);

  state_e          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [3:0]      beat_cnt_q, beat_cnt_d;

  logic [SELW-1:0] winner;
  logic            any_req;
  logic            granted;
  logic            accept;
  logic [3:0]      beat_cnt_inc;
  logic [DW-1:0]   sel_data;

  rr_pick4 u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (sel_q == SELW'(k)) sel_data = din[k*DW +: DW];
    end
  end

  assign granted      = (state_q == StGrant);
  assign out_valid    = granted & req[sel_q];
  assign out_data     = sel_data;
  assign out_last     = granted & req[sel_q] & last[sel_q];
  assign accept       = out_valid & out_ready;
  assign beat_cnt_inc = beat_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          sel_d      = winner;
          gnt_d      = NREQ'(1) << winner;
          beat_cnt_d = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        // Abort, end of burst and hold limit all release the same way; ptr
        // takes the served index so it drops to lowest priority next round.
        if (!req[sel_q] || (accept && (last[sel_q] || beat_cnt_inc == MaxHoldCnt))) begin
          ptr_d      = sel_q;
          gnt_d      = '0;
          beat_cnt_d = '0;
          state_d    = StIdle;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= 2'd3;
      sel_q      <= '0;
      gnt_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = granted;

endmodule
